osd_cmd_tx: RTL

- Initiator side of the OSD strobe bus (io_osd / io_strobe / io_din) in the clk_sys domain.
- Turns single-beat requests (OSD disable, OSD enable with optional info window, bitmap row write) into correctly framed command and payload word sequences.
- Row bitmap bytes are fetched from a 1-cycle-latency byte RAM.
- Used by the on-FPGA menu controller to drive the OSD overlay without a host processor.

---
 rtl/osd_pkg.sv | 41 ++++
 rtl/osd_strobe_phy.sv | 134 +++++++++++++
 rtl/osd_cmd_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/osd_pkg.sv
// Shared encodings and command constants for the OSD strobe-bus initiator.
package osd_pkg;

    localparam logic [1:0] OP_DISABLE = 2'd0;
    localparam logic [1:0] OP_ENABLE  = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] OP_NOP     = 2'd3;

    localparam logic [7:0] CMD_ENABLE = 8'h40;
    localparam logic [7:0] CMD_WRITE  = 8'h20;

    localparam int unsigned ROW_BYTES  = 256;
    localparam int unsigned INFO_WORDS = 5;

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StGap
    } phy_state_e;

    // Low bit of the ENABLE base doubles as the on/off flag, so DISABLE is the bare base.
    function automatic logic [15:0] cmd_word(
        input logic [1:0] op,
        input logic       info,
        input logic       nostatus,
        input logic       highres,
        input logic [4:0] row
    );
        logic [7:0] w_lo;
        w_lo = 8'h00;
        case (op)
            OP_DISABLE: w_lo = CMD_ENABLE;
            OP_ENABLE:  w_lo = CMD_ENABLE | {4'b0000, nostatus, info, 2'b01};
            OP_WRITE:   w_lo = CMD_WRITE | {4'b0000, highres, 3'b000} | {3'b000, row};
            default:    w_lo = 8'h00;
        endcase
        return {8'h00, w_lo};
    endfunction

endpackage

// File: rtl/osd_strobe_phy.sv
// Strobe-bus word timing: LO/HI phases per word, GAP after the frame, and the io_* registers.
module osd_strobe_phy
    import osd_pkg::*;
#(
    parameter int unsigned STROBE_LO = 2,
    parameter int unsigned STROBE_HI = 2,
    parameter int unsigned GAP       = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        i_word_valid,
    input  logic        i_word_last,
    input  logic        i_word_fetch,
    input  logic [15:0] i_word,
    input  logic [7:0]  i_rd_data,
    output logic        o_word_accept,
    output logic        o_fetch,
    output logic        o_done,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din
);

    if (STROBE_LO < 2) begin : g_chk_lo
        $error("osd_strobe_phy: STROBE_LO must be >= 2");
    end
    if (STROBE_HI < 1) begin : g_chk_hi
        $error("osd_strobe_phy: STROBE_HI must be >= 1");
    end
    if (GAP < 2) begin : g_chk_gap
        $error("osd_strobe_phy: GAP must be >= 2");
    end

    localparam logic [7:0] LO_LAST  = 8'(STROBE_LO - 1);
    localparam logic [7:0] HI_LAST  = 8'(STROBE_HI - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
    localparam logic [7:0] GAP_PRE  = 8'(GAP - 2);

    phy_state_e  r_state;
    logic [7:0]  r_tmr;
    logic        r_osd;
    logic        r_strobe;
    logic [15:0] r_din;
    logic        r_pass;
    logic        r_last;
    logic        r_fetch_word;
    logic        r_done;

    logic        w_hi_end;
    logic [15:0] w_next_din;

    assign w_hi_end      = (r_state == StHi) && (r_tmr == HI_LAST);
    assign o_word_accept = i_word_valid && ((r_state == StIdle) || (w_hi_end && !r_last));
    assign o_fetch       = (r_state == StLo) && r_fetch_word && (r_tmr == 8'd0);
    assign w_next_din    = i_word_fetch ? r_din : i_word;

    // RAM data is passed straight through in LO cycle 2, then held in r_din for the rest of the word.
    assign io_din    = r_pass ? {8'h00, i_rd_data} : r_din;
    assign io_osd    = r_osd;
    assign io_strobe = r_strobe;
    assign o_done    = r_done;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_tmr        <= 8'd0;
            r_osd        <= 1'b0;
            r_strobe     <= 1'b0;
            r_din        <= 16'h0000;
            r_pass       <= 1'b0;
            r_last       <= 1'b0;
            r_fetch_word <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (o_word_accept) begin
                        r_state      <= StLo;
                        r_tmr        <= 8'd0;
                        r_osd        <= 1'b1;
                        r_din        <= w_next_din;
                        r_last       <= i_word_last;
                        r_fetch_word <= i_word_fetch;
                    end
                end
                StLo: begin
                    r_tmr <= r_tmr + 8'd1;
                    if (o_fetch) begin
                        r_pass <= 1'b1;
                    end
                    if (r_pass) begin
                        r_pass <= 1'b0;
                        r_din  <= {8'h00, i_rd_data};
                    end
                    if (r_tmr == LO_LAST) begin
                        r_state  <= StHi;
                        r_tmr    <= 8'd0;
                        r_strobe <= 1'b1;
                    end
                end
                StHi: begin
                    r_tmr <= r_tmr + 8'd1;
                    if (w_hi_end) begin
                        r_tmr    <= 8'd0;
                        r_strobe <= 1'b0;
                        if (o_word_accept) begin
                            r_state      <= StLo;
                            r_din        <= w_next_din;
                            r_last       <= i_word_last;
                            r_fetch_word <= i_word_fetch;
                        end else begin
                            r_state <= StGap;
                            r_osd   <= 1'b0;
                            r_din   <= 16'h0000;
                        end
                    end
                end
                StGap: begin
                    r_tmr <= r_tmr + 8'd1;
                    if (r_tmr == GAP_PRE) begin
                        r_done <= 1'b1;
                    end
                    if (r_tmr == GAP_LAST) begin
                        r_state <= StIdle;
                        r_tmr   <= 8'd0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/osd_cmd_tx.sv
// OSD strobe-bus initiator: latches requests, sequences command/payload words, addresses the row RAM.
// Define OSD_TX_BURST_EN to let WRITE stream req_nrows+1 consecutive rows after one command.
module osd_cmd_tx
    import osd_pkg::*;
#(
    parameter int unsigned STROBE_LO = 2,
    parameter int unsigned STROBE_HI = 2,
    parameter int unsigned GAP       = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_row,
    input  logic        req_highres,
    input  logic [4:0]  req_nrows,
    input  logic        req_info,
    input  logic        req_nostatus,
    input  logic [11:0] req_infox,
    input  logic [11:0] req_infoy,
    input  logic [5:0]  req_infow,
    input  logic [5:0]  req_infoh,
    input  logic [1:0]  req_rot,
    output logic        rd_en,
    output logic [12:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        done
);

`ifdef OSD_TX_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    logic        r_ready;
    logic        r_active;
    logic        r_nop_done;
    logic [1:0]  r_op;
    logic [11:0] r_infox;
    logic [11:0] r_infoy;
    logic [5:0]  r_infow;
    logic [5:0]  r_infoh;
    logic [1:0]  r_rot;
    logic [8:0]  r_cnt;
    logic [12:0] r_addr;
    logic [4:0]  r_rows_left;

    logic        w_accept;
    logic        w_word_valid;
    logic        w_word_last;
    logic        w_word_fetch;
    logic [15:0] w_word;
    logic        w_word_accept;
    logic        w_fetch;
    logic        w_phy_done;

    assign w_accept  = req_valid && r_ready;
    assign req_ready = r_ready;
    assign rd_en     = w_fetch;
    assign rd_addr   = r_addr;
    assign done      = w_phy_done || r_nop_done;

    // While idle the command word comes straight from the request inputs so it lands on the accept edge.
    always_comb begin
        w_word_valid = 1'b0;
        w_word_last  = 1'b1;
        w_word_fetch = 1'b0;
        w_word       = 16'h0000;
        if (!r_active) begin
            w_word_valid = w_accept && (req_op != OP_NOP);
            w_word       = cmd_word(req_op, req_info, req_nostatus, req_highres, req_row);
            w_word_last  = (req_op == OP_DISABLE) || ((req_op == OP_ENABLE) && !req_info);
        end else begin
            case (r_op)
                OP_ENABLE: begin
                    w_word_valid = 1'b1;
                    w_word_last  = (r_cnt == 9'(INFO_WORDS - 1));
                    case (r_cnt)
                        9'd0:    w_word = {4'b0000, r_infox};
                        9'd1:    w_word = {4'b0000, r_infoy};
                        9'd2:    w_word = {10'b0, r_infow};
                        9'd3:    w_word = {10'b0, r_infoh};
                        default: w_word = {14'b0, r_rot};
                    endcase
                end
                OP_WRITE: begin
                    w_word_valid = 1'b1;
                    w_word_fetch = 1'b1;
                    w_word_last  = (r_addr[7:0] == 8'(ROW_BYTES - 1)) && (r_rows_left == 5'd0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ready     <= 1'b0;
            r_active    <= 1'b0;
            r_nop_done  <= 1'b0;
            r_op        <= OP_NOP;
            r_infox     <= 12'h000;
            r_infoy     <= 12'h000;
            r_infow     <= 6'h00;
            r_infoh     <= 6'h00;
            r_rot       <= 2'b00;
            r_cnt       <= 9'd0;
            r_addr      <= 13'h0000;
            r_rows_left <= 5'd0;
        end else begin
            r_nop_done <= w_accept && (req_op == OP_NOP);
            if (w_accept) begin
                r_ready     <= 1'b0;
                r_active    <= 1'b1;
                r_op        <= req_op;
                r_infox     <= req_infox;
                r_infoy     <= req_infoy;
                r_infow     <= req_infow;
                r_infoh     <= req_infoh;
                r_rot       <= req_rot;
                r_cnt       <= 9'd0;
                r_addr      <= {req_row, 8'h00};
                r_rows_left <= req_nrows & {5{BURST_EN}};
            end else begin
                if (done) begin
                    r_ready  <= 1'b1;
                    r_active <= 1'b0;
                end else if (!r_active) begin
                    r_ready <= 1'b1;
                end
                if (w_word_accept) begin
                    r_cnt <= r_cnt + 9'd1;
                end
                // Row index rolls over naturally with the 13-bit address.
                if (w_fetch) begin
                    r_addr <= r_addr + 13'd1;
                    if ((r_addr[7:0] == 8'hFF) && (r_rows_left != 5'd0)) begin
                        r_rows_left <= r_rows_left - 5'd1;
                    end
                end
            end
        end
    end

    osd_strobe_phy #(
        .STROBE_LO (STROBE_LO),
        .STROBE_HI (STROBE_HI),
        .GAP       (GAP)
    ) u_phy (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .i_word_valid  (w_word_valid),
        .i_word_last   (w_word_last),
        .i_word_fetch  (w_word_fetch),
        .i_word        (w_word),
        .i_rd_data     (rd_data),
        .o_word_accept (w_word_accept),
        .o_fetch       (w_fetch),
        .o_done        (w_phy_done),
        .io_osd        (io_osd),
        .io_strobe     (io_strobe),
        .io_din        (io_din)
    );

endmodule
